// File: rtl/controller_pkg.sv
// Shared definitions for the multi-cycle RV32I controller: FSM state encoding,
// opcode constants, ALU operation codes, datapath mux select encodings and
// the immediate-format decode helper.
package controller_pkg;

  localparam int unsigned STATE_W  = 4;
  localparam int unsigned OPCODE_W = 7;
  localparam int unsigned ALU_W    = 3;
  localparam int unsigned SEL_W    = 2;
  localparam int unsigned IMM_W    = 3;

  typedef enum logic [STATE_W-1:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_EXECI    = 4'd7,
    S_ALUWB    = 4'd8,
    S_BRANCH   = 4'd9,
    S_JAL      = 4'd10,
    S_JALR     = 4'd11,
    S_JALRLINK = 4'd12,
    S_LUI      = 4'd13
  } state_t;

  localparam logic [OPCODE_W-1:0] OP_LOAD   = 7'b0000011;
  localparam logic [OPCODE_W-1:0] OP_STORE  = 7'b0100011;
  localparam logic [OPCODE_W-1:0] OP_RTYPE  = 7'b0110011;
  localparam logic [OPCODE_W-1:0] OP_ITYPE  = 7'b0010011;
  localparam logic [OPCODE_W-1:0] OP_BRANCH = 7'b1100011;
  localparam logic [OPCODE_W-1:0] OP_JAL    = 7'b1101111;
  localparam logic [OPCODE_W-1:0] OP_JALR   = 7'b1100111;
  localparam logic [OPCODE_W-1:0] OP_LUI    = 7'b0110111;

  localparam logic [ALU_W-1:0] ALU_ADD = 3'b000;
  localparam logic [ALU_W-1:0] ALU_SUB = 3'b001;
  localparam logic [ALU_W-1:0] ALU_AND = 3'b010;
  localparam logic [ALU_W-1:0] ALU_OR  = 3'b011;
  localparam logic [ALU_W-1:0] ALU_XOR = 3'b100;
  localparam logic [ALU_W-1:0] ALU_SLT = 3'b101;

  localparam logic [SEL_W-1:0] RES_ALUOUT    = 2'b00;
  localparam logic [SEL_W-1:0] RES_DATA      = 2'b01;
  localparam logic [SEL_W-1:0] RES_ALURESULT = 2'b10;
  localparam logic [SEL_W-1:0] RES_IMMEXT    = 2'b11;

  localparam logic [SEL_W-1:0] SRCA_PC    = 2'b00;
  localparam logic [SEL_W-1:0] SRCA_OLDPC = 2'b01;
  localparam logic [SEL_W-1:0] SRCA_RD1   = 2'b10;

  localparam logic [SEL_W-1:0] SRCB_RD2  = 2'b00;
  localparam logic [SEL_W-1:0] SRCB_IMM  = 2'b01;
  localparam logic [SEL_W-1:0] SRCB_FOUR = 2'b10;

  localparam logic [IMM_W-1:0] IMM_I = 3'b000;
  localparam logic [IMM_W-1:0] IMM_S = 3'b001;
  localparam logic [IMM_W-1:0] IMM_B = 3'b010;
  localparam logic [IMM_W-1:0] IMM_J = 3'b011;
  localparam logic [IMM_W-1:0] IMM_U = 3'b100;

  // Immediate format depends only on the opcode, independent of FSM state.
  function automatic logic [IMM_W-1:0] imm_src_f(input logic [OPCODE_W-1:0] op);
    logic [IMM_W-1:0] r;
    case (op)
      OP_STORE:  r = IMM_S;
      OP_BRANCH: r = IMM_B;
      OP_JAL:    r = IMM_J;
      OP_LUI:    r = IMM_U;
      default:   r = IMM_I;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/alu_decoder.sv
// ALU operation decode for the execute states.
// Ports: funct3_i/funct7b5_i - instruction fields; is_rtype_i - 1 in EXECR,
// 0 in EXECI; alu_control_o - combinational ALU operation code.
module alu_decoder
  import controller_pkg::*;
(
  input  logic [2:0]       funct3_i,
  input  logic             funct7b5_i,
  input  logic             is_rtype_i,
  output logic [ALU_W-1:0] alu_control_o
);

  // funct7b5 only selects sub for register-register ops; addi ignores it.
  always_comb begin
    alu_control_o = ALU_ADD;
    case (funct3_i)
      3'b000:  alu_control_o = (is_rtype_i && funct7b5_i) ? ALU_SUB : ALU_ADD;
      3'b111:  alu_control_o = ALU_AND;
      3'b110:  alu_control_o = ALU_OR;
      3'b100:  alu_control_o = ALU_XOR;
      3'b010:  alu_control_o = ALU_SLT;
      default: alu_control_o = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/multi_cycle_controller.sv
// Moore control FSM for the multi-cycle RV32I datapath. Sequences each
// instruction through fetch/decode/execute/memory/writeback and drives all
// datapath mux selects, register enables and the ALU operation.
// Inputs: clk, rst_n (sync, active-low), opcode/funct3/funct7b5 from IR,
// zero/lt ALU flags (used only in BRANCH).
// Outputs (combinational from state + IR fields): pc_write, adr_src,
// mem_write, ir_write, result_src, alu_src_a, alu_src_b, reg_write,
// alu_control, imm_src.
// Build option: define BRANCH_EXT_EN to resolve bne/blt/bge in addition to beq.
module multi_cycle_controller
  import controller_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic [OPCODE_W-1:0] opcode,
  input  logic [2:0]          funct3,
  input  logic                funct7b5,
  input  logic                zero,
  input  logic                lt,
  output logic                pc_write,
  output logic                adr_src,
  output logic                mem_write,
  output logic                ir_write,
  output logic [SEL_W-1:0]    result_src,
  output logic [SEL_W-1:0]    alu_src_a,
  output logic [SEL_W-1:0]    alu_src_b,
  output logic                reg_write,
  output logic [ALU_W-1:0]    alu_control,
  output logic [IMM_W-1:0]    imm_src
);

  state_t           state_q, state_d;
  logic [ALU_W-1:0] dec_alu_c;
  logic             taken_c;

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= S_FETCH;
    else        state_q <= state_d;
  end

  alu_decoder u_alu_decoder (
    .funct3_i      (funct3),
    .funct7b5_i    (funct7b5),
    .is_rtype_i    (state_q == S_EXECR),
    .alu_control_o (dec_alu_c)
  );

  // Branch resolution from the ALU flags of the BRANCH-cycle subtraction
`ifdef BRANCH_EXT_EN
  always_comb begin
    taken_c = 1'b0;
    case (funct3)
      3'b000:  taken_c = zero;
      3'b001:  taken_c = !zero;
      3'b100:  taken_c = lt;
      3'b101:  taken_c = !lt;
      default: taken_c = 1'b0;
    endcase
  end
`else
  logic unused_lt;
  assign unused_lt = lt;

  always_comb begin
    taken_c = 1'b0;
    if (funct3 == 3'b000) taken_c = zero;
  end
`endif

  // Next-state and Moore outputs
  always_comb begin
    state_d     = state_q;
    pc_write    = 1'b0;
    adr_src     = 1'b0;
    mem_write   = 1'b0;
    ir_write    = 1'b0;
    result_src  = RES_ALUOUT;
    alu_src_a   = SRCA_PC;
    alu_src_b   = SRCB_RD2;
    reg_write   = 1'b0;
    alu_control = ALU_ADD;
    imm_src     = imm_src_f(opcode);

    case (state_q)
      S_FETCH: begin
        ir_write   = 1'b1;
        alu_src_b  = SRCB_FOUR;
        result_src = RES_ALURESULT;
        pc_write   = 1'b1;
        state_d    = S_DECODE;
      end
      S_DECODE: begin
        // Precompute branch/jal target into ALUOut
        alu_src_a = SRCA_OLDPC;
        alu_src_b = SRCB_IMM;
        case (opcode)
          OP_LOAD, OP_STORE: state_d = S_MEMADR;
          OP_RTYPE:          state_d = S_EXECR;
          OP_ITYPE:          state_d = S_EXECI;
          OP_BRANCH:         state_d = S_BRANCH;
          OP_JAL:            state_d = S_JAL;
          OP_JALR:           state_d = S_JALR;
          OP_LUI:            state_d = S_LUI;
          default:           state_d = S_FETCH;
        endcase
      end
      S_MEMADR: begin
        alu_src_a = SRCA_RD1;
        alu_src_b = SRCB_IMM;
        state_d   = opcode[5] ? S_MEMWRITE : S_MEMREAD;
      end
      S_MEMREAD: begin
        adr_src = 1'b1;
        state_d = S_MEMWB;
      end
      S_MEMWB: begin
        result_src = RES_DATA;
        reg_write  = 1'b1;
        state_d    = S_FETCH;
      end
      S_MEMWRITE: begin
        adr_src   = 1'b1;
        mem_write = 1'b1;
        state_d   = S_FETCH;
      end
      S_EXECR: begin
        alu_src_a   = SRCA_RD1;
        alu_src_b   = SRCB_RD2;
        alu_control = dec_alu_c;
        state_d     = S_ALUWB;
      end
      S_EXECI: begin
        alu_src_a   = SRCA_RD1;
        alu_src_b   = SRCB_IMM;
        alu_control = dec_alu_c;
        state_d     = S_ALUWB;
      end
      S_ALUWB: begin
        reg_write = 1'b1;
        state_d   = S_FETCH;
      end
      S_BRANCH: begin
        alu_src_a   = SRCA_RD1;
        alu_src_b   = SRCB_RD2;
        alu_control = ALU_SUB;
        pc_write    = taken_c;
        state_d     = S_FETCH;
      end
      S_JAL: begin
        // Target already in ALUOut; ALU forms OldPC+4 for the link write
        alu_src_a = SRCA_OLDPC;
        alu_src_b = SRCB_FOUR;
        pc_write  = 1'b1;
        state_d   = S_ALUWB;
      end
      S_JALR: begin
        alu_src_a  = SRCA_RD1;
        alu_src_b  = SRCB_IMM;
        result_src = RES_ALURESULT;
        pc_write   = 1'b1;
        state_d    = S_JALRLINK;
      end
      S_JALRLINK: begin
        alu_src_a  = SRCA_OLDPC;
        alu_src_b  = SRCB_FOUR;
        result_src = RES_ALURESULT;
        reg_write  = 1'b1;
        state_d    = S_FETCH;
      end
      S_LUI: begin
        result_src = RES_IMMEXT;
        reg_write  = 1'b1;
        state_d    = S_FETCH;
      end
      default: state_d = S_FETCH;
    endcase

    // Reset aborts the current instruction and suppresses every side effect
    if (!rst_n) begin
      state_d     = S_FETCH;
      pc_write    = 1'b0;
      adr_src     = 1'b0;
      mem_write   = 1'b0;
      ir_write    = 1'b0;
      result_src  = RES_ALUOUT;
      alu_src_a   = SRCA_PC;
      alu_src_b   = SRCB_RD2;
      reg_write   = 1'b0;
      alu_control = ALU_ADD;
      imm_src     = IMM_I;
    end
  end

endmodule

// File: doc/multi_cycle_controller.md
# multi_cycle_controller

Control unit of the multi-cycle RV32I datapath: a Moore state machine that sequences each instruction through fetch, decode, execute, memory and writeback. It sits directly upstream of the datapath's 2:1 and 4:1 select muxes and drives every mux select, register enable and the ALU operation. It decodes the instruction register and consumes the ALU flags.

## Interface
- No parameters.
- clk  in  1  rising-edge clock
- rst_n  in  1  synchronous, active-low reset
- opcode  in  7  instr[6:0] from IR
- funct3  in  3  instr[14:12]
- funct7b5  in  1  instr[30]
- zero  in  1  ALU result == 0
- lt  in  1  ALU signed less-than flag (valid during sub)
- pc_write  out  1  PC register enable
- adr_src  out  1  memory address: 0=PC, 1=Result
- mem_write  out  1  data memory write enable
- ir_write  out  1  IR/OldPC enable
- result_src  out  2  00 ALUOut, 01 Data, 10 ALUResult, 11 ImmExt
- alu_src_a  out  2  00 PC, 01 OldPC, 10 RD1
- alu_src_b  out  2  00 RD2, 01 ImmExt, 10 constant 4
- reg_write  out  1  register file write enable
- alu_control  out  3  000 add, 001 sub, 010 and, 011 or, 100 xor, 101 slt
- imm_src  out  3  000 I, 001 S, 010 B, 011 J, 100 U

## Operation
- States (4-bit): FETCH 0, DECODE 1, MEMADR 2, MEMREAD 3, MEMWB 4, MEMWRITE 5, EXECR 6, EXECI 7, ALUWB 8, BRANCH 9, JAL 10, JALR 11, JALRLINK 12, LUI 13.
- FETCH: adr_src=0, ir_write=1, a=00, b=10, add, result_src=10, pc_write=1 -> DECODE.
- DECODE: a=01, b=01, add (branch/jal target into ALUOut). Next state by opcode: 0000011/0100011 -> MEMADR; 0110011 -> EXECR; 0010011 -> EXECI; 1100011 -> BRANCH; 1101111 -> JAL; 1100111 -> JALR; 0110111 -> LUI; any other opcode -> FETCH (NOP).
- MEMADR: a=10, b=01, add -> MEMREAD if opcode[5]=0, else MEMWRITE.
- MEMREAD: result_src=00, adr_src=1 -> MEMWB. MEMWB: result_src=01, reg_write=1 -> FETCH.
- MEMWRITE: result_src=00, adr_src=1, mem_write=1 -> FETCH.
- EXECR: a=10, b=00, ALU decode -> ALUWB. EXECI: a=10, b=01, ALU decode -> ALUWB.
- ALUWB: result_src=00, reg_write=1 -> FETCH.
- BRANCH: a=10, b=00, sub, result_src=00, pc_write=taken -> FETCH. funct3 000 (beq): taken=zero.
- JAL: a=01, b=10, add, result_src=00, pc_write=1 -> ALUWB (writes OldPC+4).
- JALR: a=10, b=01, add, result_src=10, pc_write=1 -> JALRLINK. JALRLINK: a=01, b=10, add, result_src=10, reg_write=1 -> FETCH.
- LUI: result_src=11, reg_write=1 -> FETCH.
- ALU decode (EXECR/EXECI): funct3 000 -> sub if EXECR and funct7b5 else add; 111 and; 110 or; 100 xor; 010 slt; other funct3 -> add.
- Unlisted outputs in a state: enables 0, selects 00, alu_control add.
- imm_src is a combinational function of opcode in every state: 0100011 S, 1100011 B, 1101111 J, 0110111 U, else I.

## Timing
- Outputs are combinational from current state plus IR fields; no output registers.
- While rst_n=0 at a rising edge: state <- FETCH. While rst_n is low, pc_write, ir_write, mem_write and reg_write are forced 0. All selects and alu_control = 0.
- Reset asserted mid-instruction aborts it. No write enable is asserted in the cycle rst_n is low.
- Cycles per instruction: lw 5, sw 4, R/I 4, branch 3, jal 4, jalr 4, lui 3, unknown opcode 2.
- zero/lt are sampled only in BRANCH, in the same cycle.

## Configuration
- BRANCH_EXT_EN defined: BRANCH also resolves bne (001, taken=!zero), blt (100, taken=lt) and bge (101, taken=!lt).
- BRANCH_EXT_EN undefined: only beq is taken-capable. Every other funct3 in BRANCH gives pc_write=0. Cycle count is unchanged.

## Structure
- controller_pkg holds: the state enum; opcode constants; ALU control codes; result_src/alu_src_a/alu_src_b/imm_src encodings.
- One sub-module, alu_decoder: combinational funct3/funct7b5/state-class -> alu_control. The FSM and branch resolution stay in multi_cycle_controller.

## Test plan
- Reset held 3 cycles mid-MEMADR, then released -> all enables 0 during reset; next cycle is FETCH with pc_write=1, ir_write=1.
- lw (opcode 0000011) -> states 0,1,2,3,4,0; reg_write=1 only in MEMWB with result_src=01.
- R-type sub (funct3 000, funct7b5=1) -> EXECR alu_control=001; add-immediate with funct7b5=1 -> EXECI alu_control=000.
- beq with zero=1 -> pc_write=1 in BRANCH; zero=0 -> pc_write=0; both return to FETCH after 3 cycles.
- bne with zero=0 -> pc_write=1 only when BRANCH_EXT_EN is defined, 0 otherwise; blt with lt=1 behaves the same way.
- jalr -> JALR pc_write=1, result_src=10; then JALRLINK reg_write=1, a=01, b=10. Opcode 1111111 -> DECODE then FETCH with no enables asserted.
